multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control FSM that sequences the shared-memory multicycle MIPS datapath one instruction at a time through fetch, decode, execute, memory and write-back. Supported instructions are ADD, SUB, AND, OR, SLT, ADDI, LW, SW, SLTI and BEQ. The block holds no datapath state. It decodes `op_i`/`funct_i` from the datapath instruction register and drives every mux select, write strobe and memory request. It also counts retired instructions and flags unsupported encodings.

## Interface
- `ADD_FN`, 6'h20, ADD funct code; `SUB_FN` 6'h22, `AND_FN` 6'h24, `OR_FN` 6'h25, `SLT_FN` 6'h2A likewise
- `ADDI_OP`, 6'h08, ADDI opcode; `LW_OP` 6'h23, `SW_OP` 6'h2B, `SLTI_OP` 6'h0A, `BEQ_OP` 6'h04 likewise
- `clk_i` in 1: single clock, all state updates on its rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `op_i` in 6: IR[31:26]
- `funct_i` in 6: IR[5:0]
- `mem_ready_i` in 1: memory completes the request in the cycle this is high
- `pc_write_o` out 1: write PC unconditionally
- `branch_o` out 1: write PC if ALU zero (the datapath gates it)
- `pc_src_o` out 1: 0 = ALU result, 1 = branch-target register
- `ir_write_o` out 1: load IR from memory read data
- `mem_req_o` out 1: memory request
- `mem_we_o` out 1: request is a write
- `iord_o` out 1: memory address, 0 = PC, 1 = ALUOut
- `reg_write_o` out 1: register-file write enable
- `reg_dst_o` out 1: destination register, 0 = rt, 1 = rd
- `mem_to_reg_o` out 1: write-back data, 0 = ALUOut, 1 = MDR
- `alu_src_a_o` out 1: ALU A input, 0 = PC, 1 = register A
- `alu_src_b_o` out 2: ALU B input, 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- `alu_op_o` out 3: 000 add, 001 sub, 010 and, 011 or, 100 slt
- `state_o` out 4: current state code
- `instr_done_o` out 1: one-cycle retire pulse
- `retired_o` out 32: retired-instruction count, wraps modulo 2^32
- `illegal_o` out 1: sticky unsupported-encoding flag

## Operation
- Each state has a code: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10. Any other code returns to FETCH.
- FETCH: drives `mem_req_o`=1, `iord_o`=0, A=PC, B=4, add.
  - The block holds FETCH while `mem_ready_i`=0.
  - In the ready cycle it pulses `ir_write_o` and `pc_write_o` (`pc_src_o`=0), then moves to DECODE.
- DECODE: computes the branch target with A=PC, B=11, add. The next state depends on the instruction:
  - R-type with a supported funct -> EXEC_R.
  - ADDI or SLTI -> EXEC_I.
  - LW or SW -> MEM_ADDR.
  - BEQ -> BRANCH.
  - Anything else sets `illegal_o` and returns to FETCH. There is no retire and no count.
- EXEC_R: A=1, B=00, `alu_op_o` taken from funct -> WB_R.
- WB_R: `reg_write_o`=1, `reg_dst_o`=1, `mem_to_reg_o`=0, retire -> FETCH.
- EXEC_I: A=1, B=10, add for ADDI or slt for SLTI -> WB_I.
- WB_I: `reg_write_o`=1, `reg_dst_o`=0, `mem_to_reg_o`=0, retire -> FETCH.
- MEM_ADDR: A=1, B=10, add. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: `mem_req_o`=1, `iord_o`=1. The block waits for `mem_ready_i`, then goes to WB_MEM.
- WB_MEM: `reg_write_o`=1, `reg_dst_o`=0, `mem_to_reg_o`=1, retire -> FETCH.
- MEM_WR: `mem_req_o`=1, `mem_we_o`=1, `iord_o`=1. The block waits for `mem_ready_i`. The retire happens in the ready cycle, then the block goes to FETCH.
- BRANCH: A=1, B=00, sub, `branch_o`=1, `pc_src_o`=1, retire -> FETCH. The PC update depends only on the datapath ALU-zero.
- Retire: `instr_done_o`=1 for one cycle, and `retired_o` increments on the same edge.
- Outputs not listed for a state are 0.
- The request handshake is fixed:
  - `mem_req_o` stays high, with address select and write-enable stable, until the ready cycle.
  - `mem_ready_i` is ignored when no request is outstanding.

## Timing
- Outputs are combinational decodes of the state. In FETCH, `pc_write_o` and `ir_write_o` are also gated by `mem_ready_i`.
- Latency in cycles with zero memory wait states:
  - R-type, ADDI, SLTI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - Illegal encoding: 2.
- Each wait cycle adds one cycle to the instruction.
- Reset:
  - At the `rst_i` edge: state goes to FETCH, `retired_o`=0, `illegal_o`=0.
  - While `rst_i`=1, all strobes are forced to 0: `pc_write_o`, `branch_o`, `ir_write_o`, `mem_req_o`, `mem_we_o`, `reg_write_o`, `instr_done_o`.
  - Reset takes priority in every state, including mid-wait in MEM_RD, MEM_WR or FETCH. The aborted access produces no retire and no count.
- First request: `mem_req_o` rises in the first cycle with `rst_i`=0.

## Test plan
- ADD (op 0, funct 20), ready tied 1: `state_o` 0,1,2,7,0. In cycle 4, `reg_write_o`=1 and `reg_dst_o`=1; `alu_op_o`=000 in EXEC_R. `retired_o` becomes 1.
- LW with `mem_ready_i` low for 2 cycles in MEM_RD: 7 cycles total. `mem_req_o`=1 and `iord_o`=1 for 3 cycles, then WB_MEM with `mem_to_reg_o`=1.
- BEQ (op 04): 3 cycles. In BRANCH, `branch_o`=1, `pc_src_o`=1, `alu_op_o`=001, `pc_write_o`=0.
- Fetch with `mem_ready_i` low for 3 cycles: `ir_write_o` and `pc_write_o` stay 0 until the 4th cycle, when both pulse once.
- op 6'h3F, then funct 6'h00 with op 0: `illegal_o` is set after the first DECODE and stays 1. Both instructions return to FETCH in 2 cycles, and `retired_o` is unchanged.
- `rst_i` asserted in the 2nd wait cycle of MEM_WR: `mem_req_o` and `mem_we_o` are 0 that cycle. Next state is FETCH with `retired_o`=0 and `illegal_o`=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Control FSM for a shared-memory multicycle MIPS datapath.
//            Sequences each instruction through fetch, decode, execute,
//            memory and write-back. Supports ADD, SUB, AND, OR, SLT, ADDI,
//            LW, SW, SLTI and BEQ. It also counts retired instructions and
//            raises a sticky flag on unsupported encodings.
// Ports    : clk_i, rst_i (sync, active-high)
//            op_i / funct_i        - IR[31:26] / IR[5:0] from the datapath
//            mem_ready_i           - memory completes the request this cycle
//            pc_write_o, branch_o, pc_src_o, ir_write_o - PC / IR control
//            mem_req_o, mem_we_o, iord_o               - memory request
//            reg_write_o, reg_dst_o, mem_to_reg_o      - register file
//            alu_src_a_o, alu_src_b_o, alu_op_o        - ALU control
//            state_o, instr_done_o, retired_o, illegal_o - status
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  op_i,
  input  logic [5:0]  funct_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        branch_o,
  output logic        pc_src_o,
  output logic        ir_write_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [3:0]  state_o,
  output logic        instr_done_o,
  output logic [31:0] retired_o,
  output logic        illegal_o
);

  localparam logic [5:0] ADD_FN  = 6'h20;
  localparam logic [5:0] SUB_FN  = 6'h22;
  localparam logic [5:0] AND_FN  = 6'h24;
  localparam logic [5:0] OR_FN   = 6'h25;
  localparam logic [5:0] SLT_FN  = 6'h2A;
  localparam logic [5:0] RTYPE_OP = 6'h00;
  localparam logic [5:0] ADDI_OP = 6'h08;
  localparam logic [5:0] LW_OP   = 6'h23;
  localparam logic [5:0] SW_OP   = 6'h2B;
  localparam logic [5:0] SLTI_OP = 6'h0A;
  localparam logic [5:0] BEQ_OP  = 6'h04;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  state_t      r_state;
  logic [31:0] r_retired;
  logic        r_illegal;

  logic       w_rtype_ok;
  logic       w_is_imm;
  logic       w_is_mem;
  logic [2:0] w_funct_alu;

  // Only the five supported funct codes make an R-type legal.
  always_comb begin
    w_rtype_ok  = 1'b0;
    w_funct_alu = ALU_ADD;
    if (op_i == RTYPE_OP) begin
      case (funct_i)
        ADD_FN:  begin w_rtype_ok = 1'b1; w_funct_alu = ALU_ADD; end
        SUB_FN:  begin w_rtype_ok = 1'b1; w_funct_alu = ALU_SUB; end
        AND_FN:  begin w_rtype_ok = 1'b1; w_funct_alu = ALU_AND; end
        OR_FN:   begin w_rtype_ok = 1'b1; w_funct_alu = ALU_OR;  end
        SLT_FN:  begin w_rtype_ok = 1'b1; w_funct_alu = ALU_SLT; end
        default: begin w_rtype_ok = 1'b0; w_funct_alu = ALU_ADD; end
      endcase
    end
  end

  assign w_is_imm = (op_i == ADDI_OP) || (op_i == SLTI_OP);
  assign w_is_mem = (op_i == LW_OP) || (op_i == SW_OP);

  // Outputs are pure decodes of the state; FETCH write strobes and the
  // store retire additionally wait on the memory ready handshake.
  always_comb begin
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    pc_src_o     = 1'b0;
    ir_write_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALU_ADD;
    instr_done_o = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      DECODE: alu_src_b_o = 2'b11;
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = w_funct_alu;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (op_i == SLTI_OP) ? ALU_SLT : ALU_ADD;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      MEM_WR: begin
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        iord_o       = 1'b1;
        instr_done_o = mem_ready_i;
      end
      WB_R: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
      end
      WB_I: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALU_SUB;
        branch_o     = 1'b1;
        pc_src_o     = 1'b1;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
    // Reset is synchronous, so the state may still be mid-access during the
    // reset cycle; squash every strobe so the aborted access has no effect.
    if (rst_i) begin
      pc_write_o   = 1'b0;
      branch_o     = 1'b0;
      ir_write_o   = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      reg_write_o  = 1'b0;
      instr_done_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= FETCH;
      r_retired <= 32'd0;
      r_illegal <= 1'b0;
    end else begin
      if (instr_done_o) r_retired <= r_retired + 32'd1;
      case (r_state)
        FETCH:    if (mem_ready_i) r_state <= DECODE;
        DECODE: begin
          if (w_rtype_ok)          r_state <= EXEC_R;
          else if (w_is_imm)       r_state <= EXEC_I;
          else if (w_is_mem)       r_state <= MEM_ADDR;
          else if (op_i == BEQ_OP) r_state <= BRANCH;
          else begin
            r_illegal <= 1'b1;
            r_state   <= FETCH;
          end
        end
        EXEC_R:   r_state <= WB_R;
        EXEC_I:   r_state <= WB_I;
        MEM_ADDR: begin
          if (op_i == LW_OP)      r_state <= MEM_RD;
          else if (op_i == SW_OP) r_state <= MEM_WR;
          else                    r_state <= FETCH;
        end
        MEM_RD:   if (mem_ready_i) r_state <= WB_MEM;
        MEM_WR:   if (mem_ready_i) r_state <= FETCH;
        WB_R, WB_I, WB_MEM, BRANCH: r_state <= FETCH;
        default:  r_state <= FETCH;
      endcase
    end
  end

  assign state_o   = r_state;
  assign retired_o = r_retired;
  assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. Each cycle the bench
//            pushes the expected control word and retire count, then pops
//            and compares against the DUT on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6, S_WB_R = 4'd7, S_WB_I = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9, S_BRANCH = 4'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        pc_write, branch, pc_src, ir_write, mem_req, mem_we, iord;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct),
    .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .branch_o(branch), .pc_src_o(pc_src),
    .ir_write_o(ir_write), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .iord_o(iord), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .state_o(state),
    .instr_done_o(instr_done), .retired_o(retired), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [21:0] vec;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_ret = 32'd0;
  logic        exp_ill = 1'b0;

  // Expected control word for a state, from the state-by-state output table.
  // Layout: {state, pc_write, branch, pc_src, ir_write, mem_req, mem_we, iord,
  //          reg_write, reg_dst, mem_to_reg, alu_a, alu_b, alu_op, done}
  function automatic logic [20:0] model(input logic [3:0] st, input logic rdy,
                                        input logic rs, input logic [2:0] aop);
    logic pw, br, ps, irw, req, we, io, rw, rd, m2r, a, done;
    logic [1:0] b;
    logic [2:0] op3;
    {pw, br, ps, irw, req, we, io, rw, rd, m2r, a, done} = '0;
    b = 2'b00; op3 = 3'b000;
    case (st)
      S_FETCH:    begin req = 1; b = 2'b01; irw = rdy; pw = rdy; end
      S_DECODE:   b = 2'b11;
      S_EXEC_R:   begin a = 1; op3 = aop; end
      S_EXEC_I:   begin a = 1; b = 2'b10; op3 = aop; end
      S_MEM_ADDR: begin a = 1; b = 2'b10; end
      S_MEM_RD:   begin req = 1; io = 1; end
      S_MEM_WR:   begin req = 1; we = 1; io = 1; done = rdy; end
      S_WB_R:     begin rw = 1; rd = 1; done = 1; end
      S_WB_I:     begin rw = 1; done = 1; end
      S_WB_MEM:   begin rw = 1; m2r = 1; done = 1; end
      S_BRANCH:   begin a = 1; op3 = 3'b001; br = 1; ps = 1; done = 1; end
      default: ;
    endcase
    if (rs) {pw, br, irw, req, we, rw, done} = '0;
    return {st, pw, br, ps, irw, req, we, io, rw, rd, m2r, a, b, op3, done};
  endfunction

  // One clock cycle with the inputs already driven: push the expectation,
  // compare at the falling edge, then advance the bench's own counters.
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [2:0] aop, input logic ill_set);
    exp_t e, g;
    logic [20:0] m;
    logic [21:0] obs;
    m     = model(st, mem_ready, rst, aop);
    e.tag = tag;
    e.vec = {m, exp_ill};
    e.ret = exp_ret;
    sb.push_back(e);
    @(negedge clk);
    g   = sb.pop_front();
    obs = {state, pc_write, branch, pc_src, ir_write, mem_req, mem_we, iord,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           instr_done, illegal};
    n_tests++;
    assert (obs === g.vec) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %h expected %h", g.tag, obs, g.vec);
    end
    n_tests++;
    assert (retired === g.ret) else begin
      n_fail++;
      $error("FAIL %s retired: observed %0d expected %0d", g.tag, retired, g.ret);
    end
    @(posedge clk);
    if (rst) begin
      exp_ret = 32'd0;
      exp_ill = 1'b0;
    end else begin
      if (m[0]) exp_ret = exp_ret + 32'd1;
      if (ill_set) exp_ill = 1'b1;
    end
    #1;
  endtask

  logic [5:0] fn_tab [5];
  logic [2:0] aop_tab[5];

  initial begin
    fn_tab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    aop_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    rst = 1'b1; op = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset", S_FETCH, 3'b000, 1'b0);
    rst = 1'b0;

    // All five R-type functs, zero wait states: 0,1,2,7 then back to 0.
    for (int i = 0; i < 5; i++) begin
      op = 6'h00; funct = fn_tab[i]; mem_ready = 1'b1;
      cyc("r_fetch",  S_FETCH,  3'b000, 1'b0);
      cyc("r_decode", S_DECODE, 3'b000, 1'b0);
      cyc("r_exec",   S_EXEC_R, aop_tab[i], 1'b0);
      cyc("r_wb",     S_WB_R,   3'b000, 1'b0);
    end

    // ADDI then SLTI.
    op = 6'h08; funct = 6'h3F;
    cyc("addi_fetch", S_FETCH, 3'b000, 1'b0);
    cyc("addi_dec",   S_DECODE, 3'b000, 1'b0);
    cyc("addi_exec",  S_EXEC_I, 3'b000, 1'b0);
    cyc("addi_wb",    S_WB_I,   3'b000, 1'b0);
    op = 6'h0A;
    cyc("slti_fetch", S_FETCH, 3'b000, 1'b0);
    cyc("slti_dec",   S_DECODE, 3'b000, 1'b0);
    cyc("slti_exec",  S_EXEC_I, 3'b100, 1'b0);
    cyc("slti_wb",    S_WB_I,   3'b000, 1'b0);

    // LW with two wait cycles in MEM_RD: 7 cycles total.
    op = 6'h23;
    cyc("lw_fetch", S_FETCH, 3'b000, 1'b0);
    mem_ready = 1'b0;  // ignored outside a request
    cyc("lw_dec",   S_DECODE, 3'b000, 1'b0);
    cyc("lw_addr",  S_MEM_ADDR, 3'b000, 1'b0);
    cyc("lw_wait1", S_MEM_RD, 3'b000, 1'b0);
    cyc("lw_wait2", S_MEM_RD, 3'b000, 1'b0);
    mem_ready = 1'b1;
    cyc("lw_rd",    S_MEM_RD, 3'b000, 1'b0);
    cyc("lw_wb",    S_WB_MEM, 3'b000, 1'b0);

    // SW, zero wait.
    op = 6'h2B;
    cyc("sw_fetch", S_FETCH, 3'b000, 1'b0);
    cyc("sw_dec",   S_DECODE, 3'b000, 1'b0);
    cyc("sw_addr",  S_MEM_ADDR, 3'b000, 1'b0);
    cyc("sw_wr",    S_MEM_WR, 3'b000, 1'b0);

    // BEQ: 3 cycles.
    op = 6'h04;
    cyc("beq_fetch",  S_FETCH, 3'b000, 1'b0);
    cyc("beq_dec",    S_DECODE, 3'b000, 1'b0);
    cyc("beq_branch", S_BRANCH, 3'b001, 1'b0);

    // Fetch with three wait cycles, then an ADD.
    op = 6'h00; funct = 6'h20; mem_ready = 1'b0;
    cyc("fw_wait1", S_FETCH, 3'b000, 1'b0);
    cyc("fw_wait2", S_FETCH, 3'b000, 1'b0);
    cyc("fw_wait3", S_FETCH, 3'b000, 1'b0);
    mem_ready = 1'b1;
    cyc("fw_ready", S_FETCH,  3'b000, 1'b0);
    cyc("fw_dec",   S_DECODE, 3'b000, 1'b0);
    cyc("fw_exec",  S_EXEC_R, 3'b000, 1'b0);
    cyc("fw_wb",    S_WB_R,   3'b000, 1'b0);

    // Illegal opcode, then illegal funct: 2 cycles each, sticky flag.
    op = 6'h3F; funct = 6'h20;
    cyc("ill_op_fetch", S_FETCH,  3'b000, 1'b0);
    cyc("ill_op_dec",   S_DECODE, 3'b000, 1'b1);
    op = 6'h00; funct = 6'h00;
    cyc("ill_fn_fetch", S_FETCH,  3'b000, 1'b0);
    cyc("ill_fn_dec",   S_DECODE, 3'b000, 1'b1);

    // SW aborted by reset in its second wait cycle.
    op = 6'h2B;
    cyc("swr_fetch", S_FETCH, 3'b000, 1'b0);
    cyc("swr_dec",   S_DECODE, 3'b000, 1'b0);
    cyc("swr_addr",  S_MEM_ADDR, 3'b000, 1'b0);
    mem_ready = 1'b0;
    cyc("swr_wait1", S_MEM_WR, 3'b000, 1'b0);
    rst = 1'b1;
    cyc("swr_rst",   S_MEM_WR, 3'b000, 1'b0);
    rst = 1'b0;
    cyc("swr_after", S_FETCH, 3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
